// File: rtl/mp1_imem_loader_if.sv
// Byte-stream loader bundle: command/receive inputs plus instruction-memory
// write port and processor-reset/status outputs.
interface mp1_imem_loader_if #(
    parameter int unsigned ADDR_W = 6
) ();
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, rx_valid, rx_data,
        input  imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, err
    );

    modport slave (
        input  start, rx_valid, rx_data,
        output imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, err
    );
endinterface

// File: rtl/mp1_imem_loader.sv
// Loads a framed byte stream (HDR, N, 4*N MSB-first word bytes, XOR checksum)
// into instruction memory and holds the processor in reset until a good frame lands.
module mp1_imem_loader #(
    parameter int unsigned ADDR_W = 6,
    parameter logic [7:0]  HDR    = 8'hA5
) (
    input  logic MCLK,
    input  logic RST,
    mp1_imem_loader_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_HDR = 3'd1,
        S_LEN      = 3'd2,
        S_DATA     = 3'd3,
        S_CSUM     = 3'd4,
        S_DONE     = 3'd5,
        S_ERR      = 3'd6
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_widx;
    logic [ADDR_W-1:0] r_last;
    logic [1:0]        r_bcnt;
    logic [7:0]        r_csum;
    logic [23:0]       r_word;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_cpu_rst;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_widx_nxt;
    logic [ADDR_W-1:0] w_last_nxt;
    logic [1:0]        w_bcnt_nxt;
    logic [7:0]        w_csum_nxt;
    logic [23:0]       w_word_nxt;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [31:0]       w_wdata_nxt;
    logic              w_cpu_rst_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;

    logic              w_len_bad;
    logic              w_word_end;
    logic [31:0]       w_word_shift;

    // Length byte must describe 1..DEPTH words.
    assign w_len_bad    = (bus.rx_data == 8'd0) || (32'(bus.rx_data) > DEPTH);
    assign w_word_end   = (r_bcnt == 2'd3);
    assign w_word_shift = {r_word, bus.rx_data};

    // State and datapath registers.
    always_ff @(posedge MCLK or negedge RST) begin
        if (!RST) begin
            r_state   <= S_IDLE;
            r_widx    <= '0;
            r_last    <= '0;
            r_bcnt    <= 2'd0;
            r_csum    <= 8'd0;
            r_word    <= 24'd0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= 32'd0;
            r_cpu_rst <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_widx    <= w_widx_nxt;
            r_last    <= w_last_nxt;
            r_bcnt    <= w_bcnt_nxt;
            r_csum    <= w_csum_nxt;
            r_word    <= w_word_nxt;
            r_we      <= w_we_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_cpu_rst <= w_cpu_rst_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Next-state logic; start only matters in the resting states.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) w_state_nxt = S_WAIT_HDR;
            end
            S_WAIT_HDR: begin
                if (bus.rx_valid && (bus.rx_data == HDR)) w_state_nxt = S_LEN;
            end
            S_LEN: begin
                if (bus.rx_valid) w_state_nxt = w_len_bad ? S_ERR : S_DATA;
            end
            S_DATA: begin
                if (bus.rx_valid && w_word_end && (r_widx == r_last)) w_state_nxt = S_CSUM;
            end
            S_CSUM: begin
                if (bus.rx_valid) w_state_nxt = (bus.rx_data == r_csum) ? S_DONE : S_ERR;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and status next values.
    always_comb begin
        w_widx_nxt  = r_widx;
        w_last_nxt  = r_last;
        w_bcnt_nxt  = r_bcnt;
        w_csum_nxt  = r_csum;
        w_word_nxt  = r_word;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;

        case (r_state)
            S_LEN: begin
                if (bus.rx_valid && !w_len_bad) begin
                    w_widx_nxt = '0;
                    w_last_nxt = ADDR_W'(32'(bus.rx_data) - 32'd1);
                    w_bcnt_nxt = 2'd0;
                    w_csum_nxt = 8'd0;
                    w_word_nxt = 24'd0;
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    w_csum_nxt = r_csum ^ bus.rx_data;
                    w_word_nxt = w_word_shift[23:0];
                    w_bcnt_nxt = r_bcnt + 2'd1;
                    if (w_word_end) begin
                        w_we_nxt    = 1'b1;
                        w_addr_nxt  = r_widx;
                        w_wdata_nxt = w_word_shift;
                        if (r_widx != r_last) w_widx_nxt = r_widx + ADDR_W'(1);
                    end
                end
            end
            default: ;
        endcase

        // Status flags track the state being entered so they change on the same edge.
        w_busy_nxt    = (w_state_nxt == S_WAIT_HDR) || (w_state_nxt == S_LEN) ||
                        (w_state_nxt == S_DATA)     || (w_state_nxt == S_CSUM);
        w_done_nxt    = (w_state_nxt == S_DONE);
        w_err_nxt     = (w_state_nxt == S_ERR);
        w_cpu_rst_nxt = (w_state_nxt != S_DONE);
    end

    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.cpu_rst    = r_cpu_rst;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
endmodule

// File: tb/tb_mp1_imem_loader.sv
// Bench for mp1_imem_loader: directed frames plus randomized frames scored
// against a frame-parsing reference model.
module tb_mp1_imem_loader;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam logic [7:0]  HDR    = 8'hA5;
    localparam int O_BUSY = 0, O_DONE = 1, O_ERR = 2;

    logic MCLK;
    logic RST;
    int   vectors = 0;
    int   miscompares = 0;

    mp1_imem_loader_if #(.ADDR_W(ADDR_W)) bus ();
    mp1_imem_loader #(.ADDR_W(ADDR_W), .HDR(HDR)) dut (.MCLK(MCLK), .RST(RST), .bus(bus));

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    logic [7:0]  tx_q[$];
    logic [7:0]  seq[$];
    int          got_addr[$];
    logic [31:0] got_data[$];
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write monitor and mutual-exclusion check on status flags.
    always @(negedge MCLK) begin
        if (RST === 1'b1) begin
            if (bus.imem_we === 1'b1) begin
                got_addr.push_back(int'(bus.imem_addr));
                got_data.push_back(bus.imem_wdata);
            end
            if (bus.done === 1'b1 || bus.err === 1'b1)
                chk("done_err_excl", 32'(bus.done & bus.err), 32'd0);
        end
    end

    // Reference: parse everything received since start as one frame.
    task automatic run_model();
        int i, n;
        logic [7:0]  cs;
        logic [31:0] w;
        exp_addr.delete();
        exp_data.delete();
        exp_out = O_BUSY;
        i = 0;
        while (i < tx_q.size() && tx_q[i] != HDR) i++;
        if (i >= tx_q.size()) return;
        i++;
        if (i >= tx_q.size()) return;
        n = int'(tx_q[i]);
        i++;
        if (n == 0 || n > int'(DEPTH)) begin
            exp_out = O_ERR;
            return;
        end
        cs = 8'd0;
        for (int k = 0; k < n; k++) begin
            if (i + 4 > tx_q.size()) return;
            w = {tx_q[i], tx_q[i+1], tx_q[i+2], tx_q[i+3]};
            cs = cs ^ tx_q[i] ^ tx_q[i+1] ^ tx_q[i+2] ^ tx_q[i+3];
            exp_addr.push_back(k);
            exp_data.push_back(w);
            i += 4;
        end
        if (i >= tx_q.size()) return;
        exp_out = (tx_q[i] == cs) ? O_DONE : O_ERR;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge MCLK);
            #1;
        end
    endtask

    task automatic pulse_start(input bit with_byte, input logic [7:0] b);
        tx_q.delete();
        got_addr.delete();
        got_data.delete();
        bus.start    = 1'b1;
        bus.rx_valid = with_byte;
        bus.rx_data  = b;
        @(posedge MCLK);
        #1;
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tx_q.push_back(b);
        @(posedge MCLK);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_seq(input int gapmax, input int start_at);
        for (int k = 0; k < seq.size(); k++) begin
            if (k == start_at) begin
                bus.start = 1'b1;
                @(posedge MCLK);
                #1;
                bus.start = 1'b0;
            end
            send(seq[k]);
            idle(int'($urandom_range(gapmax, 0)));
        end
    endtask

    task automatic check_frame(input string tag);
        run_model();
        chk({tag, "_nwr"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
            chk({tag, "_addr"}, 32'(got_addr[k]), 32'(exp_addr[k]));
            chk({tag, "_data"}, got_data[k], exp_data[k]);
        end
        chk({tag, "_done"},    32'(bus.done),    32'(exp_out == O_DONE));
        chk({tag, "_err"},     32'(bus.err),     32'(exp_out == O_ERR));
        chk({tag, "_busy"},    32'(bus.busy),    32'(exp_out == O_BUSY));
        chk({tag, "_cpu_rst"}, 32'(bus.cpu_rst), 32'(exp_out != O_DONE));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_we"},      32'(bus.imem_we),    32'd0);
        chk({tag, "_addr"},    32'(bus.imem_addr),  32'd0);
        chk({tag, "_wdata"},   bus.imem_wdata,      32'd0);
        chk({tag, "_cpu_rst"}, 32'(bus.cpu_rst),    32'd1);
        chk({tag, "_busy"},    32'(bus.busy),       32'd0);
        chk({tag, "_done"},    32'(bus.done),       32'd0);
        chk({tag, "_err"},     32'(bus.err),        32'd0);
    endtask

    initial begin
        logic [7:0] b, cs;
        int n, nj;
        bit bad_len, mid_start;

        bus.start = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'd0;
        RST = 1'b0;
        #12;
        chk_reset_vals("reset");
        @(posedge MCLK);
        #1;
        RST = 1'b1;
        idle(2);

        // Single word, good checksum.
        pulse_start(1'b0, 8'h00);
        seq = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        send_seq(0, -1);
        idle(2);
        check_frame("r031");

        // Leading junk, two words, gaps between bytes.
        pulse_start(1'b0, 8'h00);
        seq = '{8'h33, 8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03,
                8'h04, 8'h05, 8'h06, 8'h07, 8'h00};
        send_seq(2, -1);
        idle(2);
        check_frame("r032");

        // Bad checksum.
        pulse_start(1'b0, 8'h00);
        seq = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        send_seq(0, -1);
        idle(2);
        check_frame("r033");

        // Zero length, then oversize length.
        pulse_start(1'b0, 8'h00);
        seq = '{8'hA5, 8'h00};
        send_seq(0, -1);
        idle(2);
        check_frame("r034a");
        pulse_start(1'b0, 8'h00);
        seq = '{8'hA5, 8'h41};
        send_seq(0, -1);
        idle(2);
        check_frame("r034b");

        // Reset mid-frame, then header without start is ignored.
        pulse_start(1'b0, 8'h00);
        seq = '{8'hA5, 8'h01, 8'h12, 8'h34};
        send_seq(0, -1);
        #2;
        RST = 1'b0;
        #1;
        chk_reset_vals("r035_rst");
        @(posedge MCLK);
        #1;
        RST = 1'b1;
        got_addr.delete();
        got_data.delete();
        seq = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        send_seq(0, -1);
        idle(2);
        chk_reset_vals("r035_after");
        chk("r035_nwr", 32'(got_addr.size()), 32'd0);

        // Restart from DONE with a header byte in the start cycle.
        pulse_start(1'b0, 8'h00);
        seq = '{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        send_seq(1, -1);
        idle(2);
        check_frame("r036_pre");
        pulse_start(1'b1, HDR);
        chk("r036_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        chk("r036_done",    32'(bus.done),    32'd0);
        chk("r036_busy",    32'(bus.busy),    32'd1);
        seq = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        send_seq(0, -1);
        idle(2);
        check_frame("r036_wait");
        seq = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        send_seq(0, -1);
        idle(2);
        check_frame("r036_load");

        // Randomized frames.
        for (int f = 0; f < 24; f++) begin
            pulse_start(1'($urandom_range(1, 0)), 8'($urandom));
            seq.delete();
            nj = int'($urandom_range(2, 0));
            for (int k = 0; k < nj; k++) begin
                b = 8'($urandom);
                if (b == HDR) b = ~b;
                seq.push_back(b);
            end
            seq.push_back(HDR);
            bad_len = ($urandom_range(5, 0) == 0);
            mid_start = 1'b0;
            if (bad_len) begin
                seq.push_back(($urandom_range(1, 0) == 0) ? 8'd0 : 8'($urandom_range(255, DEPTH + 1)));
            end else begin
                n = int'($urandom_range(8, 1));
                if (f == 23) n = int'(DEPTH);
                seq.push_back(8'(n));
                cs = 8'd0;
                for (int k = 0; k < 4 * n; k++) begin
                    b = 8'($urandom);
                    cs = cs ^ b;
                    seq.push_back(b);
                end
                if ($urandom_range(3, 0) == 0) cs = cs ^ 8'($urandom_range(255, 1));
                seq.push_back(cs);
                mid_start = ($urandom_range(2, 0) == 0);
            end
            send_seq((f == 23) ? 0 : 2, mid_start ? seq.size() / 2 : -1);
            idle(2);
            check_frame("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mp1_imem_loader.md
MP1_IMEM_LOADER -- requirements
Module: mp1_imem_loader

Interface
REQ-001 Parameter ADDR_W, default 6, instruction-memory address width (depth 2**ADDR_W words).
REQ-002 Parameter HDR, default 8'hA5, frame header byte.
REQ-003 MCLK  input  1  sole clock; all state changes on rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to begin a load frame.
REQ-006 rx_valid  input  1  rx_data is valid this cycle; may be high on consecutive cycles.
REQ-007 rx_data  input  8  received byte.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  ADDR_W  word address for imem_wdata.
REQ-010 imem_wdata  output  32  instruction word.
REQ-011 cpu_rst  output  1  active-high reset to the processor top; held while not loaded.
REQ-012 busy  output  1  frame reception in progress.
REQ-013 done  output  1  last frame loaded and checksum matched.
REQ-014 err  output  1  last frame rejected.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT_HDR, LEN, DATA, CSUM, DONE and ERR.
REQ-016 In IDLE, DONE or ERR, start=1 SHALL move to WAIT_HDR and on that edge set busy=1, cpu_rst=1, done=0 and err=0; any rx_valid byte in that cycle is discarded.
REQ-017 start SHALL be ignored in WAIT_HDR, LEN, DATA and CSUM.
REQ-018 WAIT_HDR: an rx_valid byte equal to HDR SHALL advance to LEN; any other byte is discarded with no state change.
REQ-019 LEN: the rx_valid byte is N; if N==0 or N>2**ADDR_W, go to ERR; otherwise go to DATA with word index=0, byte count=0, checksum=0.
REQ-020 DATA: each rx_valid byte SHALL be shifted into the word MSB-first and XORed into the 8-bit checksum.
REQ-021 On the edge that samples the 4th byte of a word, imem_addr SHALL take the word index, imem_wdata the assembled word, and imem_we SHALL be 1 for exactly the following cycle (latency 1 cycle from last byte).
REQ-022 After word N-1 is written, go to CSUM; byte count wraps 3->0 and the word index increments per word without exceeding N-1.
REQ-023 CSUM: an rx_valid byte equal to the accumulated checksum SHALL go to DONE, any other value to ERR.
REQ-024 DONE: done=1, busy=0, cpu_rst=0; state held until start.
REQ-025 ERR: err=1, busy=0, cpu_rst=1; state held until start.
REQ-026 Cycles with rx_valid=0 SHALL not change any state, counter or checksum.
REQ-027 imem_we SHALL be 0 in every cycle not covered by REQ-021; imem_addr and imem_wdata hold their last values.
REQ-028 done and err SHALL never be 1 simultaneously.

Reset
REQ-029 RST=0 SHALL immediately force IDLE, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, busy=0, done=0, err=0, and clear all counters and the checksum.
REQ-030 RST asserted mid-frame SHALL abandon the frame; after release, the first HDR byte is accepted only after a new start.

Verification
REQ-031 start; bytes A5,01,12,34,56,78,08 -> one imem_we pulse: addr 0, data 32'h12345678; then done=1, cpu_rst=0.
REQ-032 start; bytes 33,A5,02 then 8 data bytes 00..07, then checksum 00 -> 0x33 ignored; writes 32'h00010203@0 and 32'h04050607@1; done=1.
REQ-033 Same as REQ-031 with checksum 09 -> no done; err=1, cpu_rst=1, busy=0.
REQ-034 start; bytes A5,00 -> err=1; then start; A5,41 with ADDR_W=6 -> err=1 (65>64).
REQ-035 RST low after the 2nd data byte of REQ-031 -> all outputs at reset values, no imem_we; a later A5 without start is ignored.
REQ-036 In DONE: start with rx_valid=1 (data A5) the same cycle -> cpu_rst=1, done=0, busy=1; the A5 is discarded and the FSM waits in WAIT_HDR.
